// File: rtl/sms_timing_pkg.sv
// Shared definitions for the SMS memory timing ring.
// Holds the time-point count, FSM state type and index type.
package sms_timing_pkg;

   localparam int NUM_TP = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef logic [3:0] tp_idx_t;

   // One-hot decode of a time-point index; indices >= NUM_TP give zero.
   function automatic logic [NUM_TP-1:0] tp_onehot(tp_idx_t i);
      logic [NUM_TP-1:0] one;
      one = 1;
      return one << i;
   endfunction

endpackage

// File: rtl/sms_tp_divider.sv
// Sub-counter dividing x down to one time point (DIV clocks).
// Ports: x, reset_n, en (count), cnt_nxt (next count), last (count = DIV-1).
module sms_tp_divider #(
   parameter int DIV = 4,
   parameter int CW  = $clog2(DIV)
) (
   input  logic          x,
   input  logic          reset_n,
   input  logic          en,
   output logic [CW-1:0] cnt_nxt,
   output logic          last
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      last  = (cnt_q == CW'(DIV - 1));
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      cnt_nxt = cnt_d;
   end

   always_ff @(posedge x or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sms_timing_ring.sv
// Ten-point memory timing ring with AC trigger and selectable gate.
// Ports: x, reset_n, run, step, gate_sel -> tp, ac, gate, cyc_end, busy.
module sms_timing_ring
   import sms_timing_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic              x,
   input  logic              reset_n,
   input  logic              run,
   input  logic              step,
   input  logic [3:0]        gate_sel,
   output logic [NUM_TP-1:0] tp,
   output logic              ac,
   output logic              gate,
   output logic              cyc_end,
   output logic              busy
);

   localparam int CW = $clog2(DIV);

   state_e  state_q, state_d;
   tp_idx_t idx_q, idx_d;

   logic [CW-1:0] sub_nxt;
   logic          sub_last;

   logic [NUM_TP-1:0] tp_q, tp_d;
   logic ac_q, ac_d;
   logic gate_q, gate_d;
   logic cyc_end_q, cyc_end_d;
   logic busy_q, busy_d;

   sms_tp_divider #(
      .DIV (DIV),
      .CW  (CW)
   ) u_div (
      .x       (x),
      .reset_n (reset_n),
      .en      (state_q == RUN),
      .cnt_nxt (sub_nxt),
      .last    (sub_last)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (run || step) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (sub_last) begin
               if (idx_q == tp_idx_t'(NUM_TP - 1)) begin
                  idx_d = '0;
                  if (!run) begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up
   // with the state they describe, with no input-to-output path.
   always_comb begin
      busy_d    = (state_d == RUN);
      tp_d      = busy_d ? tp_onehot(idx_d) : '0;
      ac_d      = busy_d && (sub_nxt < CW'(DIV / 2));
      gate_d    = busy_d && (gate_sel < 4'(NUM_TP))
                  && (idx_d == gate_sel);
      cyc_end_d = busy_d && (idx_d == tp_idx_t'(NUM_TP - 1))
                  && (sub_nxt == CW'(DIV - 1));
   end

   always_ff @(posedge x or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         tp_q      <= '0;
         ac_q      <= 1'b0;
         gate_q    <= 1'b0;
         cyc_end_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tp_q      <= tp_d;
         ac_q      <= ac_d;
         gate_q    <= gate_d;
         cyc_end_q <= cyc_end_d;
         busy_q    <= busy_d;
      end
   end

   assign tp      = tp_q;
   assign ac      = ac_q;
   assign gate    = gate_q;
   assign cyc_end = cyc_end_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_sms_timing_ring.sv
// Self-checking bench for sms_timing_ring (DIV=4).
// Reference model tracks cycle position 0..10*DIV-1 and a busy flag.
module tb_sms_timing_ring;

   localparam int DIV = 4;
   localparam int CYC = 10 * DIV;

   logic       x;
   logic       reset_n;
   logic       run;
   logic       step;
   logic [3:0] gate_sel;
   logic [9:0] tp;
   logic       ac;
   logic       gate;
   logic       cyc_end;
   logic       busy;

   int n_chk;
   int n_pass;

   int m_busy;
   int m_p;
   int m_gs;

   sms_timing_ring #(.DIV(DIV)) dut (
      .x        (x),
      .reset_n  (reset_n),
      .run      (run),
      .step     (step),
      .gate_sel (gate_sel),
      .tp       (tp),
      .ac       (ac),
      .gate     (gate),
      .cyc_end  (cyc_end),
      .busy     (busy)
   );

   initial x = 1'b0;
   always #5 x = ~x;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: advance the model at the edge, compare at the negedge.
   task automatic tick();
      logic [9:0] e_tp;
      logic [3:0] e_ctl;
      @(posedge x);
      if (!reset_n) begin
         m_busy = 0;
         m_p    = 0;
      end else if (m_busy == 0) begin
         if (run || step) begin
            m_busy = 1;
            m_p    = 0;
         end
      end else if (m_p == CYC - 1) begin
         if (run) m_p = 0;
         else     m_busy = 0;
      end else begin
         m_p++;
      end
      m_gs = int'(gate_sel);
      @(negedge x);
      e_tp  = '0;
      e_ctl = '0;
      if (m_busy != 0) begin
         e_tp[m_p / DIV] = 1'b1;
         e_ctl[3] = (m_p % DIV) < DIV / 2;
         e_ctl[2] = (m_gs < 10) && (m_p / DIV == m_gs);
         e_ctl[1] = (m_p == CYC - 1);
         e_ctl[0] = 1'b1;
      end
      chk("tp", 32'(tp), 32'(e_tp));
      chk("ctl", 32'({ac, gate, cyc_end, busy}), 32'(e_ctl));
   endtask

   task automatic drain();
      int k;
      run  = 1'b0;
      step = 1'b0;
      k = 0;
      while (m_busy != 0 && k < 60) begin
         tick();
         k++;
      end
      if (m_busy != 0) chk("drain_bound", 0, 1);
   endtask

   task automatic wait_tp(input int t);
      int k;
      k = 0;
      while (!(m_busy != 0 && m_p / DIV == t) && k < 60) begin
         tick();
         k++;
      end
      if (k >= 60) chk("wait_bound", 0, 1);
   endtask

   initial begin
      int ncyc;
      int nbusy;
      int ngate;
      n_chk    = 0;
      n_pass   = 0;
      m_busy   = 0;
      m_p      = 0;
      m_gs     = 0;
      reset_n  = 1'b0;
      run      = 1'b0;
      step     = 1'b0;
      gate_sel = 4'd0;

      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();

      // continuous run with gate on T5
      gate_sel = 4'd5;
      run      = 1'b1;
      ncyc     = 0;
      ngate    = 0;
      for (int i = 0; i < 85; i++) begin
         tick();
         if (cyc_end) ncyc++;
         if (gate) ngate++;
      end
      chk("run_ncyc", ncyc, 2);
      chk("run_ngate", ngate, 2 * DIV);

      // drop run during T3: cycle must complete
      wait_tp(3);
      run  = 1'b0;
      ncyc = 0;
      for (int k = 0; k < 60 && m_busy != 0; k++) begin
         tick();
         if (cyc_end) ncyc++;
      end
      chk("drop_ncyc", ncyc, 1);
      chk("drop_busy", 32'(busy), 0);
      repeat (3) tick();

      // single step
      step  = 1'b1;
      tick();
      step  = 1'b0;
      nbusy = busy ? 1 : 0;
      ncyc  = 0;
      for (int k = 0; k < 60 && busy; k++) begin
         tick();
         if (busy) nbusy++;
         if (cyc_end) ncyc++;
      end
      chk("step_nbusy", nbusy, CYC);
      chk("step_ncyc", ncyc, 1);
      repeat (3) tick();

      // out-of-range gate select
      gate_sel = 4'd12;
      run      = 1'b1;
      ngate    = 0;
      for (int i = 0; i < 45; i++) begin
         tick();
         if (gate) ngate++;
      end
      chk("gs12_ngate", ngate, 0);
      drain();

      // step+run together, step noise during RUN
      gate_sel = 4'd2;
      run      = 1'b1;
      step     = 1'b1;
      ncyc     = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (cyc_end) ncyc++;
         step = 1'($urandom_range(0, 1));
      end
      step = 1'b0;
      chk("sr_ncyc", ncyc, 2);

      // async reset during T6
      wait_tp(6);
      #2;
      reset_n = 1'b0;
      run     = 1'b0;
      #1;
      m_busy = 0;
      chk("arst_tp", 32'(tp), 0);
      chk("arst_ctl", 32'({ac, gate, cyc_end, busy}), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      run = 1'b1;
      repeat (6) tick();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step     = ($urandom_range(0, 19) == 0);
         gate_sel = 4'($urandom_range(0, 15));
         tick();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
